lsu: RTL and testbench

- Multi-cycle load/store unit directly downstream of the core ALU.
- Takes the ALU result as the effective address, plus MemWr, MemOP and rs2 data.
- Performs one data-memory transaction over a valid/ready request + response bus.
- Returns byte-lane-aligned, sign/zero-extended load data, which the core muxes onto the GPR write bus when MemtoReg is set.

---
 rtl/lsu.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit sitting behind the core ALU.
// One data-memory transaction at a time over a valid/ready request bus
// and a response-valid return bus. Load data is lane-aligned and
// sign/zero-extended; store data is replicated into its byte lanes.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned H/W ops complete
// immediately with rsp_err=1 and never reach memory).
module lsu #(
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  // Byte enables for a store; BU/HU encodings share the B/H lane rules.
  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] o);
    case (op)
      3'b000, 3'b100: store_mask = 4'b0001 << o;
      3'b001, 3'b101: store_mask = 4'b0011 << {o[1], 1'b0};
      default:        store_mask = 4'b1111;
    endcase
  endfunction

  // Store data replicated so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      3'b000, 3'b100: store_data = {4{wd[7:0]}};
      3'b001, 3'b101: store_data = {2{wd[15:0]}};
      default:        store_data = wd;
    endcase
  endfunction

  // Lane select plus sign/zero extension of a raw read word.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] o,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes never trap.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = a[0];
      default:        misaligned = (a != 2'b00);
    endcase
  endfunction
`endif

  logic [1:0]    state_q, state_d;
  logic          wen_q, wen_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_wen_q, mem_wen_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // Next-state and next-output computation for the IDLE/REQ/WAIT/RESP FSM.
  always_comb begin
    state_d         = state_q;
    wen_d           = wen_q;
    op_d            = op_q;
    off_d           = off_q;
    cnt_d           = cnt_q;
    req_ready_d     = req_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d       = req_wen;
          op_d        = req_op;
          off_d       = req_addr[1:0];
          req_ready_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned(req_op, req_addr[1:0])) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {req_addr[31:2], 2'b00};
            mem_wen_d       = req_wen;
            mem_wmask_d     = req_wen ? store_mask(req_op, req_addr[1:0]) : 4'b0000;
            mem_wdata_d     = req_wen ? store_data(req_op, req_wdata) : 32'd0;
          end
`else
          state_d         = S_REQ;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = {req_addr[31:2], 2'b00};
          mem_wen_d       = req_wen;
          mem_wmask_d     = req_wen ? store_mask(req_op, req_addr[1:0]) : 4'b0000;
          mem_wdata_d     = req_wen ? store_data(req_op, req_wdata) : 32'd0;
`endif
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d         = S_WAIT;
          mem_req_valid_d = 1'b0;
          cnt_d           = CW'(0);
        end else begin
          mem_req_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wen_q ? 32'd0 : load_extend(op_q, off_q, mem_rsp_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        // Return the memory bus to its idle values while waiting for the next op.
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        mem_addr_d  = RESET_ADDR;
        mem_wen_d   = 1'b0;
        mem_wmask_d = 4'b0000;
        mem_wdata_d = 32'd0;
      end
      default: begin
        state_d         = S_IDLE;
        req_ready_d     = 1'b1;
        mem_req_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wen_q           <= 1'b0;
      op_q            <= 3'b000;
      off_q           <= 2'b00;
      cnt_q           <= CW'(0);
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= RESET_ADDR;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= 32'd0;
      mem_wmask_q     <= 4'b0000;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'd0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wen_q           <= wen_d;
      op_q            <= op_d;
      off_q           <= off_d;
      cnt_q           <= cnt_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed test of lsu with a response scoreboard and a
// memory-request scoreboard, each checked by a monitor at the falling edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  lsu #(.TIMEOUT(8), .RESET_ADDR(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] mask; } mreq_t;
  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mv_cnt = 0;

  // memory responder knobs
  int          rdy_delay = 0;
  bit          rsp_en    = 1'b1;
  logic [31:0] rsp_word  = 32'd0;
  bit          pending   = 1'b0;
  int          wctr      = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ready after rdy_delay cycles, one-cycle response next cycle
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (pending) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp_word;
        pending = 1'b0;
      end else if (mem_req_valid) begin
        if (wctr >= rdy_delay) begin
          mem_req_ready = 1'b1;
          wctr = 0;
          pending = rsp_en;
        end else begin
          wctr++;
        end
      end
    end
  end

  rsp_t  mon_r;
  mreq_t mon_m;
  // monitor: pop and compare whenever the DUT presents a response or a request handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid) mv_cnt++;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, expected no response", rsp_rdata);
        end else begin
          mon_r = rsp_q.pop_front();
          check32("rsp_rdata", rsp_rdata, mon_r.rdata);
          check32("rsp_err", {31'd0, rsp_err}, {31'd0, mon_r.err});
          check32("rsp_cycle", cyc, mon_r.cyc);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mreq_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_req: got request addr=%h, expected none", mem_addr);
        end else begin
          mon_m = mreq_q.pop_front();
          check32("mem_addr", mem_addr, mon_m.addr);
          check32("mem_wen", {31'd0, mem_wen}, {31'd0, mon_m.wen});
          check32("mem_wmask", {28'd0, mem_wmask}, {28'd0, mon_m.mask});
          if (mon_m.wen) check32("mem_wdata", mem_wdata, mon_m.wdata);
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit push_rsp, input logic [31:0] e_rdata,
                       input logic e_err, input int lat, input bit push_mem,
                       input logic [3:0] e_mask, input logic [31:0] e_wdata);
    mreq_t m;
    rsp_t  r;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    check32("accept_ready", {31'd0, req_ready}, 32'd1);
    if (push_mem) begin
      m.addr = {addr[31:2], 2'b00}; m.wen = wen; m.wdata = e_wdata; m.mask = e_mask;
      mreq_q.push_back(m);
    end
    if (push_rsp) begin
      r.rdata = e_rdata; r.err = e_err; r.cyc = cyc + lat;
      rsp_q.push_back(r);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rsp_q.size() != 0 || mreq_q.size() != 0) && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done: %0d responses still pending, expected 0", rsp_q.size());
      rsp_q.delete(); mreq_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv0;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_op = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    #25;
    check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check32("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'h8000_0000);
    check32("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // SB at offset 3
    rsp_word = 32'hFFFF_FFFF;
    issue(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 1, 32'd0, 1'b0, 3, 1, 4'b1000, 32'hA5A5_A5A5);
    wait_done();
    // SH upper half, SW aligned
    issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_BEEF, 1, 32'd0, 1'b0, 3, 1, 4'b1100, 32'hBEEF_BEEF);
    wait_done();
    issue(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 1, 32'd0, 1'b0, 3, 1, 4'b1111, 32'hDEAD_BEEF);
    wait_done();
    // loads from 0x12F03456
    rsp_word = 32'h12F0_3456;
    issue(1'b0, 3'b000, 32'h8000_0002, 32'd0, 1, 32'hFFFF_FFF0, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    issue(1'b0, 3'b100, 32'h8000_0002, 32'd0, 1, 32'h0000_00F0, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    issue(1'b0, 3'b001, 32'h8000_0002, 32'd0, 1, 32'h0000_12F0, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    // low-half sign vs zero extension
    rsp_word = 32'h8001_ABCD;
    issue(1'b0, 3'b001, 32'h8000_0000, 32'd0, 1, 32'hFFFF_ABCD, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    issue(1'b0, 3'b101, 32'h8000_0000, 32'd0, 1, 32'h0000_ABCD, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    // reserved op behaves as W
    rsp_word = 32'h1122_3344;
    issue(1'b0, 3'b011, 32'h8000_0008, 32'd0, 1, 32'h1122_3344, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();

    // backpressure: ready low for 4 cycles
    rdy_delay = 4; rsp_word = 32'hCAFE_F00D;
    issue(1'b0, 3'b010, 32'h8000_0010, 32'd0, 1, 32'hCAFE_F00D, 1'b0, 7, 1, 4'b0000, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("bp_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check32("bp_mem_addr", mem_addr, 32'h8000_0010);
      check32("bp_mem_wmask", {28'd0, mem_wmask}, 32'd0);
      check32("bp_mem_wen", {31'd0, mem_wen}, 32'd0);
      check32("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    wait_done();
    rdy_delay = 0;

    // timeout: no response, TIMEOUT=8
    rsp_en = 1'b0;
    issue(1'b0, 3'b010, 32'h8000_0020, 32'd0, 1, 32'd0, 1'b1, 10, 1, 4'b0000, 32'd0);
    wait_done();
    rsp_en = 1'b1; rsp_word = 32'h5555_AAAA;
    issue(1'b0, 3'b010, 32'h8000_0024, 32'd0, 1, 32'h5555_AAAA, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();

    // misaligned word access
    mv0 = mv_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h8000_0001, 32'd0, 1, 32'd0, 1'b1, 1, 0, 4'b0000, 32'd0);
    wait_done();
    issue(1'b1, 3'b001, 32'h8000_0003, 32'h0000_1234, 1, 32'd0, 1'b1, 1, 0, 4'b0000, 32'd0);
    wait_done();
    check32("trap_no_mem_req", mv_cnt - mv0, 32'd0);
`else
    issue(1'b1, 3'b010, 32'h8000_0001, 32'h0102_0304, 1, 32'd0, 1'b0, 3, 1, 4'b1111, 32'h0102_0304);
    wait_done();
    rsp_word = 32'h0BAD_F00D;
    issue(1'b0, 3'b010, 32'h8000_0001, 32'd0, 1, 32'h0BAD_F00D, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    check32("misalign_mem_req_seen", mv_cnt - mv0, 32'd2);
`endif

    // reset during WAIT, then a late response must be ignored
    rsp_en = 1'b0;
    issue(1'b0, 3'b010, 32'h8000_0030, 32'd0, 0, 32'd0, 1'b0, 0, 1, 4'b0000, 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check32("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check32("arst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check32("arst_mem_addr", mem_addr, 32'h8000_0000);
    check32("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("arst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; wctr = 0; rsp_word = 32'h7777_7777; pending = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("late_rsp_ignored", {31'd0, rsp_valid}, 32'd0);
      check32("late_rsp_idle", {31'd0, req_ready}, 32'd1);
    end
    rsp_en = 1'b1; rsp_word = 32'h0000_0081;
    issue(1'b0, 3'b000, 32'h8000_0040, 32'd0, 1, 32'hFFFF_FF81, 1'b0, 3, 1, 4'b0000, 32'd0);
    wait_done();
    check32("queues_empty", rsp_q.size() + mreq_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
